// File: rtl/pcie_tlp_pkg.sv
// TLP header constants, credit classes and the length-to-data-credit helper,
// shared by the receive-side credit return logic and any TX-side accounting.
package pcie_tlp_pkg;

  // Type field values; MWr and MRd share a type code and differ only in fmt[1].
  localparam logic [4:0] TLP_MWR     = 5'b00000;
  localparam logic [4:0] TLP_MRD     = 5'b00000;
  localparam logic [4:0] TLP_MRDLK   = 5'b00001;
  localparam logic [4:0] TLP_IO      = 5'b00010;
  localparam logic [4:0] TLP_CFG0    = 5'b00100;
  localparam logic [4:0] TLP_CFG1    = 5'b00101;
  localparam logic [1:0] TLP_MSG_PFX = 2'b10;    // compared against type[4:3]
  localparam logic [3:0] TLP_CPL_PFX = 4'b0101;  // compared against type[4:1]

  typedef enum logic [1:0] {
    CR_NONE = 2'd0,
    CR_P    = 2'd1,
    CR_NP   = 2'd2
  } cr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR1 = 2'd1,
    ST_BODY = 2'd2
  } rx_state_e;

  // ceil(len/4) data credits; a zero length field means 1024 DW (256 credits).
  function automatic logic [8:0] dw_to_data_credits(input logic [9:0] len_dw);
    logic [10:0] dw_total;
    dw_total = {(len_dw == 10'd0), len_dw};
    dw_total = dw_total + 11'd3;
    return dw_total[10:2];
  endfunction

endpackage

// File: rtl/pcie_tlp_hdr_decode.sv
// Combinational classification of a TLP header into credit class, data
// presence and the number of data credits it consumes.
module pcie_tlp_hdr_decode
  import pcie_tlp_pkg::*;
(
  input  logic [1:0] fmt_i,
  input  logic [4:0] type_i,
  input  logic [9:0] len_i,
  output cr_class_e  class_o,
  output logic       has_data_o,
  output logic [8:0] pd_credits_o
);

  logic unused_fmt;
  assign unused_fmt = fmt_i[0];

  always_comb begin
    class_o      = CR_NONE;
    has_data_o   = fmt_i[1];
    pd_credits_o = fmt_i[1] ? dw_to_data_credits(len_i) : 9'd0;
    if (type_i[4:1] == TLP_CPL_PFX) begin
      class_o = CR_NONE;
    end else if (type_i[4:3] == TLP_MSG_PFX) begin
      class_o = CR_P;
    end else if (type_i == TLP_MWR && fmt_i[1]) begin
      class_o = CR_P;
    end else if (type_i == TLP_MRD) begin
      class_o = CR_NP;
    end else if (type_i == TLP_MRDLK || type_i == TLP_IO ||
                 type_i == TLP_CFG0  || type_i == TLP_CFG1) begin
      class_o = CR_NP;
    end
  end

endmodule

// File: rtl/pcie_rx_credit_return.sv
// Returns receive-buffer credits to the ECP3 PCIe core once each inbound TLP
// has fully passed. Define RX_CREDIT_STATS_EN to add TLP statistics outputs.
module pcie_rx_credit_return
  import pcie_tlp_pkg::*;
#(
  parameter int PD_MAX_CHUNK = 255,
  parameter int HDR_CNT_W    = 8,
  parameter int PD_CNT_W     = 12
) (
  input  logic        clk_125,
  input  logic        rstn,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  input  logic        rx_malf_tlp,
  output logic        ph_cr,
  output logic        pd_cr,
  output logic [7:0]  pd_num,
  output logic        nph_cr,
  output logic        npd_cr
`ifdef RX_CREDIT_STATS_EN
  ,
  output logic [31:0] rx_posted_cnt,
  output logic [31:0] rx_nonposted_cnt,
  output logic [31:0] rx_drop_cnt
`endif
);

  rx_state_e   state_q, state_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [4:0]  type_q, type_d;
  logic [9:0]  len_q, len_d;
  logic        enq_d;

  cr_class_e   dec_class;
  logic        dec_has_data;
  logic [8:0]  dec_pd_credits;

  cr_class_e   enq_class_q, enq_class_d;
  logic        enq_has_data_q, enq_has_data_d;
  logic [8:0]  enq_pd_q, enq_pd_d;

  pcie_tlp_hdr_decode u_hdr_decode (
    .fmt_i        (fmt_q),
    .type_i       (type_q),
    .len_i        (len_q),
    .class_o      (dec_class),
    .has_data_o   (dec_has_data),
    .pd_credits_o (dec_pd_credits)
  );

  // A new rx_st always wins: it abandons any TLP in progress, and together
  // with rx_end it marks a truncated TLP.
  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    type_d  = type_q;
    len_d   = len_q;
    enq_d   = 1'b0;
    if (rx_st) begin
      if (rx_end) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_HDR1;
        fmt_d   = rx_data[14:13];
        type_d  = rx_data[12:8];
      end
    end else begin
      unique case (state_q)
        ST_HDR1: begin
          if (rx_end) begin
            state_d = ST_IDLE;
          end else begin
            len_d   = rx_data[9:0];
            state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          if (rx_end) begin
            state_d = ST_IDLE;
            enq_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    enq_class_d    = enq_d ? dec_class : CR_NONE;
    enq_has_data_d = enq_d && dec_has_data;
    enq_pd_d       = (enq_d && dec_class == CR_P) ? dec_pd_credits : 9'd0;
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      fmt_q          <= 2'd0;
      type_q         <= 5'd0;
      len_q          <= 10'd0;
      enq_class_q    <= CR_NONE;
      enq_has_data_q <= 1'b0;
      enq_pd_q       <= 9'd0;
    end else begin
      state_q        <= state_d;
      fmt_q          <= fmt_d;
      type_q         <= type_d;
      len_q          <= len_d;
      enq_class_q    <= enq_class_d;
      enq_has_data_q <= enq_has_data_d;
      enq_pd_q       <= enq_pd_d;
    end
  end

  // Header-style counters, index 0 = ph, 1 = nph, 2 = npd; one credit per pulse.
  localparam logic [HDR_CNT_W:0] HDR_MAX = {1'b0, {HDR_CNT_W{1'b1}}};

  logic [2:0] hdr_inc;
  logic [2:0] hdr_cr;

  assign hdr_inc[0] = (enq_class_q == CR_P);
  assign hdr_inc[1] = (enq_class_q == CR_NP);
  assign hdr_inc[2] = (enq_class_q == CR_NP) && enq_has_data_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hdr
      logic [HDR_CNT_W-1:0] pend_q, pend_d;
      logic [HDR_CNT_W:0]   avail, rem;
      logic                 cr_q, cr_d, sat;

      // Enqueue and drain fold into one net update so no event is lost.
      assign avail  = {1'b0, pend_q} + {{HDR_CNT_W{1'b0}}, hdr_inc[gi]};
      assign cr_d   = (avail != '0);
      assign rem    = avail - {{HDR_CNT_W{1'b0}}, cr_d};
      assign sat    = (rem > HDR_MAX);
      assign pend_d = sat ? HDR_MAX[HDR_CNT_W-1:0] : rem[HDR_CNT_W-1:0];

      always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
          pend_q <= '0;
          cr_q   <= 1'b0;
        end else begin
          pend_q <= pend_d;
          cr_q   <= cr_d;
        end
      end

      assign hdr_cr[gi] = cr_q;

`ifndef SYNTHESIS
      always @(posedge clk_125) begin
        if (rstn) begin
          assert (!sat) else $error("header credit counter %0d saturated", gi);
        end
      end
`endif
    end
  endgenerate

  assign ph_cr  = hdr_cr[0];
  assign nph_cr = hdr_cr[1];
  assign npd_cr = hdr_cr[2];

  // Posted data drains in chunks of up to PD_MAX_CHUNK credits per pulse.
  localparam logic [PD_CNT_W:0] PD_MAX   = {1'b0, {PD_CNT_W{1'b1}}};
  localparam logic [PD_CNT_W:0] PD_CHUNK = (PD_CNT_W+1)'(PD_MAX_CHUNK);

  logic [PD_CNT_W-1:0] pd_pend_q, pd_pend_d;
  logic [PD_CNT_W:0]   pd_avail, pd_drain, pd_rem;
  logic                pd_sat;
  logic                pd_cr_q, pd_cr_d;
  logic [7:0]          pd_num_q, pd_num_d;

  assign pd_avail  = {1'b0, pd_pend_q} + (PD_CNT_W+1)'(enq_pd_q);
  assign pd_drain  = (pd_avail > PD_CHUNK) ? PD_CHUNK : pd_avail;
  assign pd_cr_d   = (pd_avail != '0);
  assign pd_num_d  = pd_drain[7:0];
  assign pd_rem    = pd_avail - pd_drain;
  assign pd_sat    = (pd_rem > PD_MAX);
  assign pd_pend_d = pd_sat ? PD_MAX[PD_CNT_W-1:0] : pd_rem[PD_CNT_W-1:0];

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      pd_pend_q <= '0;
      pd_cr_q   <= 1'b0;
      pd_num_q  <= 8'd0;
    end else begin
      pd_pend_q <= pd_pend_d;
      pd_cr_q   <= pd_cr_d;
      pd_num_q  <= pd_num_d;
    end
  end

  assign pd_cr  = pd_cr_q;
  assign pd_num = pd_num_q;

`ifndef SYNTHESIS
  always @(posedge clk_125) begin
    if (rstn) begin
      assert (!pd_sat) else $error("posted data credit counter saturated");
    end
  end
`endif

  // Malformed TLPs still return credits, so rx_malf_tlp is intentionally unused.
  logic unused_sig;
  assign unused_sig = ^{rx_malf_tlp, rx_data[15], pd_drain[PD_CNT_W:8]};

`ifdef RX_CREDIT_STATS_EN
  logic [31:0] posted_cnt_q, nonposted_cnt_q, drop_cnt_q;
  logic [1:0]  drop_inc;

  // An abandon and a same-cycle truncation are two separate dropped TLPs.
  always_comb begin
    drop_inc = 2'd0;
    if (rx_st && state_q != ST_IDLE) begin
      drop_inc = drop_inc + 2'd1;
    end
    if (rx_st && rx_end) begin
      drop_inc = drop_inc + 2'd1;
    end else if (!rx_st && rx_end && state_q == ST_HDR1) begin
      drop_inc = drop_inc + 2'd1;
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      posted_cnt_q    <= 32'd0;
      nonposted_cnt_q <= 32'd0;
      drop_cnt_q      <= 32'd0;
    end else begin
      posted_cnt_q    <= posted_cnt_q + {31'd0, hdr_inc[0]};
      nonposted_cnt_q <= nonposted_cnt_q + {31'd0, hdr_inc[1]};
      drop_cnt_q      <= drop_cnt_q + {30'd0, drop_inc};
    end
  end

  assign rx_posted_cnt    = posted_cnt_q;
  assign rx_nonposted_cnt = nonposted_cnt_q;
  assign rx_drop_cnt      = drop_cnt_q;
`endif

endmodule
